// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   rx_state_t       - receiver FSM state encoding
//   BAUD_DIV_DEFAULT - default clk cycles per bit
//   parity()         - even parity of a (zero-extended) data word
package uart_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // Value of the even-parity bit: 1 when the word holds an odd number of ones.
  function automatic logic parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received words.
//   clk, rst_n : clock, async active-low reset (storage cleared to 0)
//   push, din  : write din; accepted when not full, or when full with a pop
//   pop        : remove head; ignored when empty
//   dout       : head word, combinational from storage
//   empty/full : occupancy status
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // When full, a write only fits if the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_core.sv
// uart_rx_fifo_core: UART receiver with false-start rejection, sticky
// framing/overrun/parity flags and a receive FIFO.
//   clk, rst_n : system clock, async active-low reset
//   RX         : serial line (idle high, asynchronous)
//   rd         : pop FIFO head (ignored when rdy = 0)
//   clr_err    : clear sticky error flags (a same-cycle set wins)
//   rx_data    : FIFO head word, valid while rdy = 1
//   rdy        : FIFO not empty
//   frm_err    : stop bit sampled low
//   ovr_err    : good word dropped, FIFO full
//   par_err    : parity mismatch
// Build option: define UART_RX_PARITY_EN to expect an even parity bit between
// the data bits and the stop bit; otherwise par_err is tied low.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | half-bit wait, then confirm start bit (high = glitch)
// DATA      | sample DATA_BITS data bits, LSB first
// PAR       | sample parity bit (parity build only)
// STOP      | sample stop bit, push word or flag error
// WAIT_IDLE | after framing error, wait for the line to return high
module uart_rx_fifo_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 rd,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 ovr_err,
  output logic                 par_err
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frm_err_q, frm_err_d;
  logic                 ovr_err_q, ovr_err_d;
  logic                 sample;
  logic                 word_ok, frm_set, par_set, ovr_set;
  logic                 fifo_empty, fifo_full;

  assign sample = (state_q != IDLE) && (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic par_err_q, par_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    word_ok   = 1'b0;
    frm_set   = 1'b0;
    par_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = sample ? CNT_RELOAD : cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (sample) begin
          par_bad_d = rx_s_q ^ parity(16'(shreg_q));
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (!rx_s_q) begin
            frm_set = 1'b1;
            state_d = WAIT_IDLE;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              par_set = 1'b1;
            end else begin
              word_ok = 1'b1;
            end
`else
            word_ok = 1'b1;
`endif
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous pop frees the slot, so only a pop-less push into a full FIFO overruns.
  assign ovr_set = word_ok & fifo_full & ~(rd & ~fifo_empty);

  assign frm_err_d = frm_set | (frm_err_q & ~clr_err);
  assign ovr_err_d = ovr_set | (ovr_err_q & ~clr_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      frm_err_q <= frm_err_d;
      ovr_err_q <= ovr_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_err_d = par_set | (par_err_q & ~clr_err);
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;
  assign rdy     = ~fifo_empty;

  uart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (word_ok),
    .pop  (rd),
    .din  (shreg_q),
    .dout (rx_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
module tb_uart_rx_fifo_core;

`ifdef UART_RX_PARITY_EN
  localparam int DW  = 7;
  localparam int PAR = 1;
`else
  localparam int DW  = 8;
  localparam int PAR = 0;
`endif
  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
  localparam int NBITS = DW + 2 + PAR;
  // Stop-bit sample edge, counted in clk edges from the cycle RX falls:
  // 2 sync flops + state register, then a half bit, then one bit per field.
  localparam int TS = 4 + BAUD / 2 + BAUD * (DW + 1 + PAR);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          RX = 1'b1;
  logic          rd_mon = 1'b0;
  logic          rd_dir = 1'b0;
  logic          rd;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rdy, frm_err, ovr_err, par_err;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_frm = 0, exp_ovr = 0, exp_par = 0;
  bit            mon_en = 0;

  assign rd = rd_mon | rd_dir;

  always #5 clk = ~clk;

  uart_rx_fifo_core #(
    .BAUD_DIV  (BAUD),
    .DATA_BITS (DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .rd     (rd),
    .clr_err(clr_err),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .ovr_err(ovr_err),
    .par_err(par_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_frm_err"}, 32'(frm_err), 32'(exp_frm));
    chk({tag, "_ovr_err"}, 32'(ovr_err), 32'(exp_ovr));
    chk({tag, "_par_err"}, 32'(par_err), 32'(exp_par));
  endtask

  // Drives one frame; the reference model decides the outcome just after the
  // stop sample edge using the frame's own contents and the model's occupancy.
  task automatic send_frame(input logic [DW-1:0] d, input bit par_flip, input bit stop_val,
                            input bit rd_at_stop, input bit chk_edge);
    logic [NBITS-1:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    if (PAR != 0) bits[DW+1] = (^d) ^ par_flip;
    bits[NBITS-1] = stop_val;
    for (int c = 0; c < NBITS * BAUD; c++) begin
      RX = bits[c/BAUD];
      if (c == TS - 1) begin
        if (chk_edge) chk("rdy_before_push", 32'(rdy), 0);
        if (rd_at_stop) begin
          if (exp_q.size() > 0) chk("head_at_full", 32'(rx_data), 32'(exp_q.pop_front()));
          else chk("head_at_full_model_empty", 32'(exp_q.size()), 1);
          rd_dir = 1'b1;
        end
      end
      if (c == TS) begin
        rd_dir = 1'b0;
        if (!stop_val) exp_frm = 1;
        else if (PAR != 0 && par_flip) exp_par = 1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovr = 1;
        if (chk_edge) chk("rdy_after_push", 32'(rdy), 1);
      end
      tick();
    end
    if (!stop_val) begin
      RX = 1'b0;
      repeat (40) tick();
    end
    RX = 1'b1;
    repeat (4) tick();
  endtask

  task automatic glitch();
    RX = 1'b0;
    repeat (4) tick();
    RX = 1'b1;
    repeat (20) tick();
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_frm = 0; exp_ovr = 0; exp_par = 0;
    chk_flags("clr");
  endtask

  task automatic drain();
    int n = 0;
    mon_en = 1;
    while (exp_q.size() > 0 && n < 50 * DEPTH) begin
      tick();
      n++;
    end
    repeat (4) tick();
    mon_en = 0;
    repeat (2) tick();
    chk("drain_left", 32'(exp_q.size()), 0);
    chk("rdy_after_drain", 32'(rdy), 0);
  endtask

  // Monitor: whenever enabled and the DUT presents a word, compare it with
  // the scoreboard head and pop it with a one-cycle rd pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_mon) begin
        rd_mon = 1'b0;
      end else if (mon_en && rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", rx_data);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        rd_mon = 1'b1;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] v;
    #1;
    chk("reset_rdy", 32'(rdy), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk_flags("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single frame with rdy timing around the stop sample.
    v = DW'(8'hA5);
    send_frame(v, 0, 1, 0, 1);
    chk("single_data", 32'(rx_data), 32'(v));
    chk_flags("single");
    rd_dir = 1'b1;
    tick();
    rd_dir = 1'b0;
    void'(exp_q.pop_front());
    chk("single_rdy_after_rd", 32'(rdy), 0);

    // Glitch: short low pulse must not produce a word or a flag.
    glitch();
    chk("glitch_rdy", 32'(rdy), 0);
    chk_flags("glitch");

    // Framing error with a long break, then recovery.
    send_frame(DW'(8'h3C), 0, 0, 0, 0);
    chk_flags("framing");
    chk("framing_rdy", 32'(rdy), 0);
    send_frame(DW'(8'h11), 0, 1, 0, 0);
    chk_flags("after_framing");
    drain();
    do_clr();

    // Overrun: five frames, no reads.
    for (int i = 1; i <= 5; i++) send_frame(DW'(i), 0, 1, 0, 0);
    chk_flags("overrun");
    drain();
    do_clr();

    // Full FIFO with a pop on the fifth push edge: no overrun.
    for (int i = 1; i <= 4; i++) send_frame(DW'(i), 0, 1, 0, 0);
    send_frame(DW'(5), 0, 1, 1, 0);
    chk_flags("full_pop");
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(DW'(8'h55), 0, 1, 0, 0);
    chk_flags("parity_good");
    send_frame(DW'(8'h55), 1, 1, 0, 0);
    chk_flags("parity_bad");
    drain();
    do_clr();
`endif

    // Reset mid-frame with a stored word and a set flag.
    send_frame(DW'(8'h3C), 0, 0, 0, 0);
    send_frame(DW'(8'h5A), 0, 1, 0, 0);
    chk("pre_reset_rdy", 32'(rdy), 1);
    RX = 1'b0;
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(rdy), 0);
    chk("midrst_rx_data", 32'(rx_data), 0);
    exp_q.delete();
    exp_frm = 0; exp_ovr = 0; exp_par = 0;
    chk_flags("midrst");
    RX = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    send_frame(DW'(8'h66), 0, 1, 0, 0);
    chk_flags("post_reset");
    drain();

    // Randomised frames with a reader that comes and goes.
    for (int n = 0; n < 30; n++) begin
      int r;
      bit pf, sv;
      v  = DW'($urandom);
      r  = $urandom_range(0, 9);
      sv = (r != 0);
      pf = (PAR != 0) && (r == 1);
      mon_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) glitch();
      send_frame(v, pf, sv, 0, 0);
      chk_flags("rand");
      if ((exp_frm || exp_ovr || exp_par) && $urandom_range(0, 1) == 1) do_clr();
    end
    drain();
    do_clr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
